// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the CPU memory-access stage and data_memory_unit.
//   master (CPU side):    drives MemRead, MemWrite, dataAddress, dataIn;
//                         receives dataOut, stall, addrError.
//   slave (memory side):  the mirror image.
interface data_memory_unit_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dataAddress;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        stall;
  logic        addrError;

  modport master (
    output MemRead, MemWrite, dataAddress, dataIn,
    input  dataOut, stall, addrError
  );

  modport slave (
    input  MemRead, MemWrite, dataAddress, dataIn,
    output dataOut, stall, addrError
  );
endinterface

// File: rtl/data_memory_unit.sv
// Multi-cycle data memory for the MIPS MEM stage.
// A legal request is latched in IDLE, held for LATENCY cycles under stall, and the array is
// accessed on the edge entering DONE. Misaligned, out-of-range and read+write requests are
// rejected with a one-cycle addrError pulse and never touch the array.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    slave side of data_memory_unit_if:
//            MemRead/MemWrite/dataAddress/dataIn in, dataOut (registered) / stall /
//            addrError (registered pulse) out
module data_memory_unit #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_unit_if.slave  bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} stateE;

  logic [31:0]     mem [DEPTH];

  stateE           state;
  logic [CntW-1:0] cnt;
  logic [IdxW-1:0] idxLatch;
  logic [31:0]     dataLatch;
  logic            writeLatch;
  logic [31:0]     dataOutQ;
  logic            addrErrorQ;

  logic            req;
  logic            bad;
  logic [IdxW-1:0] reqIdx;

  logic            accessEn;
  logic            accessWrite;
  logic [IdxW-1:0] accessIdx;
  logic [31:0]     accessData;

  assign req    = bus.MemRead | bus.MemWrite;
  assign bad    = (bus.dataAddress[1:0] != 2'b00) ||
                  ({2'b00, bus.dataAddress[31:2]} >= 32'(DEPTH)) ||
                  (bus.MemRead & bus.MemWrite);
  assign reqIdx = bus.dataAddress[IdxW+1:2];

  // Access on the edge that enters DONE. With LATENCY=1 that edge is the acceptance edge,
  // so the live inputs are used instead of the (not yet loaded) latches.
  always_comb begin
    accessEn    = 1'b0;
    accessWrite = 1'b0;
    accessIdx   = '0;
    accessData  = '0;
    if (reset) begin
      if (LATENCY == 1 && state == StIdle && req && !bad) begin
        accessEn    = 1'b1;
        accessWrite = bus.MemWrite;
        accessIdx   = reqIdx;
        accessData  = bus.dataIn;
      end else if (state == StBusy && req && cnt == CntW'(1)) begin
        accessEn    = 1'b1;
        accessWrite = writeLatch;
        accessIdx   = idxLatch;
        accessData  = dataLatch;
      end
    end
  end

  // Array has no reset: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (accessEn && accessWrite) begin
      mem[accessIdx] <= accessData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      cnt        <= '0;
      idxLatch   <= '0;
      dataLatch  <= '0;
      writeLatch <= 1'b0;
      dataOutQ   <= '0;
      addrErrorQ <= 1'b0;
    end else begin
      addrErrorQ <= 1'b0;
      if (accessEn && !accessWrite) begin
        dataOutQ <= mem[accessIdx];
      end
      case (state)
        StIdle: begin
          if (req && bad) begin
            addrErrorQ <= 1'b1;
          end else if (req) begin
            idxLatch   <= reqIdx;
            dataLatch  <= bus.dataIn;
            writeLatch <= bus.MemWrite;
            cnt        <= CntW'(LATENCY - 1);
            state      <= (LATENCY == 1) ? StDone : StBusy;
          end
        end
        StBusy: begin
          // A dropped request aborts the access with no side effects.
          if (!req) begin
            state <= StIdle;
          end else if (cnt == CntW'(1)) begin
            state <= StDone;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Gated by reset so a request held during reset does not report a stall.
  assign bus.stall     = reset & (((state == StIdle) & req & ~bad) | (state == StBusy));
  assign bus.dataOut   = dataOutQ;
  assign bus.addrError = addrErrorQ;

endmodule
